jk_mod_counter: RTL and testbench



---
 rtl/jk_mod_counter.sv | 98 +++++++++
 tb/tb_jk_mod_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK flip-flop cells.
// Ports: clk, rst, en, up_dn, load, din -> q, tc, err, jk_j, jk_k.
//
// jk_ff: one JK cell with synchronous active-high reset.
//   clk, rst, j, k -> q
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00: q <= q;
        2'b01: q <= 1'b0;
        2'b10: q <= 1'b1;
        2'b11: q <= ~q;
      endcase
    end
  end

endmodule

// jk_mod_counter: counter state lives only in the JK cells.
//   The next count is only ever reached by driving J/K.
//   tc is combinational; err is a registered one-cycle flag.
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             err,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k
);

  // One extra bit so MOD == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] n;
  logic             din_ok;
  logic             bad_load;
  logic             at_max;
  logic             at_zero;

  assign din_ok   = ({1'b0, din} < MODW);
  assign bad_load = load & ~din_ok;
  assign at_max   = (q == MAXV);
  assign at_zero  = (q == '0);

  always_comb begin
    n = q;
    if (load) begin
      // An illegal load freezes the count and swallows en.
      if (din_ok) n = din;
    end else if (en) begin
      if (up_dn) n = at_max ? '0 : q + ONE;
      else       n = at_zero ? MAXV : q - ONE;
    end
  end

  // Only bits that change get excited; J=K=1 can never occur.
  assign jk_j = n & ~q;
  assign jk_k = ~n & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk_j[i]),
      .k   (jk_k[i]),
      .q   (q[i])
    );
  end

  assign tc = en & ~load & ~rst &
              ((up_dn & at_max) | (~up_dn & at_zero));

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= bad_load;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed and random checks for jk_mod_counter (WIDTH=4, MOD=10).
// Expected values are hand-derived or from a small reference model.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic         tc;
  logic         err;
  logic [W-1:0] jk_j;
  logic [W-1:0] jk_k;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up_dn (up_dn),
    .load  (load),
    .din   (din),
    .q     (q),
    .tc    (tc),
    .err   (err),
    .jk_j  (jk_j),
    .jk_k  (jk_k)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic u, input logic l,
                       input logic [W-1:0] d);
    rst   = r;
    en    = e;
    up_dn = u;
    load  = l;
    din   = d;
  endtask

  int mq;
  int nq;
  int exp_q;
  logic mtc;
  logic merr;

  initial begin
    // Reset with every other control active.
    drive(1, 1, 1, 1, 4'd5);
    #1;
    check("tc_in_rst", tc, 0);
    step();
    step();
    check("rst_q", q, 0);
    check("rst_err", err, 0);
    check("rst_tc", tc, 0);

    drive(0, 0, 1, 0, 4'd0);
    #1;
    check("idle_j", jk_j, 0);
    check("idle_k", jk_k, 0);
    step();
    check("idle_q", q, 0);

    // Up count through the wrap.
    drive(0, 1, 1, 0, 4'd0);
    exp_q = 0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      check("up_tc", tc, (exp_q == 9) ? 1 : 0);
      if (exp_q == 3) begin
        check("up_j_3to4", jk_j, 4'b0100);
        check("up_k_3to4", jk_k, 4'b0011);
      end
      step();
      exp_q = i % 10;
      check("up_q", q, exp_q);
    end

    // Down count: 2 -> 1 -> 0 -> 9 -> 8.
    drive(0, 1, 0, 0, 4'd0);
    #1;
    check("dn_tc_q2", tc, 0);
    step();
    check("dn_q1", q, 1);
    check("dn_tc_q1", tc, 0);
    step();
    check("dn_q0", q, 0);
    check("dn_tc_q0", tc, 1);
    step();
    check("dn_q9", q, 9);
    check("dn_tc_q9", tc, 0);
    step();
    check("dn_q8", q, 8);

    // Legal load then illegal load with en.
    drive(0, 0, 1, 1, 4'd7);
    step();
    check("ld7_q", q, 7);
    check("ld7_err", err, 0);
    drive(0, 1, 1, 1, 4'd12);
    #1;
    check("ill_j", jk_j, 0);
    check("ill_k", jk_k, 0);
    step();
    check("ill_q", q, 7);
    check("ill_err", err, 1);
    drive(0, 0, 1, 0, 4'd0);
    step();
    check("ill_err_clr", err, 0);
    check("ill_q_hold", q, 7);

    // Back-to-back illegal loads at the boundary values.
    drive(0, 1, 0, 1, 4'd10);
    step();
    check("b2b_err1", err, 1);
    drive(0, 1, 0, 1, 4'd15);
    step();
    check("b2b_err2", err, 1);
    check("b2b_q", q, 7);
    drive(0, 0, 1, 1, 4'd9);
    step();
    check("ld9_q", q, 9);
    check("ld9_err", err, 0);

    // Load masks tc at the terminal value.
    drive(0, 1, 1, 1, 4'd2);
    #1;
    check("tc_load_mask", tc, 0);
    step();
    check("ld2_q", q, 2);

    // Direction change at q=9 with no dead cycle.
    drive(0, 0, 1, 1, 4'd9);
    step();
    drive(0, 1, 0, 0, 4'd0);
    step();
    check("dir_q8", q, 8);

    // Load beats en; then reset beats en.
    drive(0, 1, 1, 1, 4'd3);
    step();
    check("prio_q", q, 3);
    drive(1, 1, 1, 0, 4'd0);
    #1;
    check("rst_mid_tc", tc, 0);
    step();
    check("rst_mid_q", q, 0);
    check("rst_mid_err", err, 0);
    drive(0, 1, 1, 0, 4'd0);
    step();
    check("resume_q", q, 1);

    // Random run against a reference model.
    mq   = 1;
    merr = 0;
    for (int c = 0; c < 1000; c++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
            W'($urandom_range(0, 15)));
      #1;
      nq   = mq;
      merr = 0;
      mtc  = 0;
      if (rst) begin
        nq = 0;
      end else if (load) begin
        if (din < M) nq = din;
        else merr = 1;
      end else if (en) begin
        if (up_dn) begin
          mtc = (mq == M - 1);
          nq  = (mq == M - 1) ? 0 : mq + 1;
        end else begin
          mtc = (mq == 0);
          nq  = (mq == 0) ? M - 1 : mq - 1;
        end
      end
      check("rnd_tc", tc, mtc);
      check("rnd_jk_excl", jk_j & jk_k, 0);
      step();
      mq = nq;
      check("rnd_q", q, mq);
      check("rnd_err", err, merr);
      check("rnd_q_lt_mod", (q < M) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
